seq_borrow_subtractor: RTL and testbench
========================================

// Module: seq_borrow_subtractor
// PURPOSE
//  Word-serial unsigned subtractor: diff = a - b - bin, computed one DIGIT-bit slice per cycle, LSB slice first.
//  Each slice uses a borrow-lookahead cell. The slice borrow is registered between cycles.
//  Complements the combinational carry-lookahead adder in the arithmetic library: subtract direction, area-lean, valid/ready on both sides.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be an integer multiple of DIGIT
//  DIGIT  4   bits processed per cycle (slice width)
//  NDIG   WIDTH/DIGIT  derived localparam, not overridable; number of RUN cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a, b, bin valid
//  in_ready   out  1      block accepts operands (high only in IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      diff/bout valid (DONE state)
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  result
//  bout       out  1      borrow out (1 = a < b + bin)
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, digit counter=0, borrow reg=0, diff=0, bout=0, out_valid=0, busy=0.
//  - in_ready = (state==IDLE) & ~rst.
//  - IDLE: on in_valid & in_ready at edge k: capture a, b; borrow reg <= bin; cnt <= 0; -> RUN.
//  - RUN: each cycle, slice cnt of a and b goes through bla_slice with borrow reg.
//      Result slice is written into diff[cnt*DIGIT +: DIGIT]; borrow reg <= slice borrow out; cnt <= cnt+1.
//      When cnt==NDIG-1: bout <= slice borrow out; -> DONE.
//  - DONE: out_valid=1. diff and bout are held stable until out_ready. On out_valid & out_ready: -> IDLE, out_valid drops next cycle.
//  - Latency: operands accepted at edge k -> out_valid high after edge k+NDIG. Minimum issue interval NDIG+2 cycles.
//  - Backpressure: in DONE with out_ready=0 the block stalls indefinitely; in_valid is ignored (in_ready=0).
//  - diff holds its last value in IDLE; it is not cleared between operations. Slices not yet written during RUN hold stale data.
//  - Arithmetic: modulo 2^WIDTH, unsigned; bout is the final slice borrow. bin=1 with a==b gives all-ones and bout=1.
//  - Reset mid-RUN/DONE aborts the operation; no partial result is flagged.
//  - cnt width = $clog2(NDIG), min 1. NDIG==1 is legal: one RUN cycle.
// CONFIGURATION
//  SUB_SAT_EN defined: on the final RUN cycle, if the slice borrow out=1, diff is forced to 0 (saturate at zero). bout is still reported as 1.
//  SUB_SAT_EN undefined: wrap-around result, as described above. Port list is identical in both builds.
// STRUCTURE
//  Package sub_pkg: state encoding localparams ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10.
//    Also a shared function width_ok(WIDTH,DIGIT) used for the elaboration check.
//  Sub-module bla_slice #(DIGIT): combinational borrow-lookahead.
//    g = ~a & b, p = ~(a ^ b), br[i+1] = g[i] | p[i] & br[i], d = a ^ b ^ br.
//    Outputs d[DIGIT] and the slice borrow out.
//  Top: FSM, counter, operand registers, borrow register, result register. One bla_slice instance.
// TESTING (WIDTH=16, DIGIT=4)
//  1. a=16'h1234, b=16'h0234, bin=0 -> out_valid 4 cycles after accept; diff=16'h1000, bout=0.
//  2. a=16'h1000, b=16'h0001 -> diff=16'h0FFF, bout=0 (borrow ripples across 3 slices).
//  3. a=16'h0000, b=16'h0001 -> diff=16'hFFFF, bout=1. With SUB_SAT_EN: diff=16'h0000, bout=1.
//  4. a=b=16'h8000, bin=1 -> diff=16'hFFFF, bout=1 (diff=0 with SUB_SAT_EN).
//  5. out_ready=0 for 5 cycles in DONE with in_valid=1 -> diff/bout stable, in_ready=0, no new capture; accept resumes 1 cycle after handshake.
//  6. Assert rst in the 2nd RUN cycle -> out_valid=0, busy=0, diff=0, bout=0 immediately. in_ready=1 after rst falls; a fresh op then completes correctly.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the word-serial borrow subtractor.
// State encoding and the WIDTH/DIGIT legality check used at elaboration.
package sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // WIDTH must be a positive whole multiple of a positive DIGIT
    function automatic bit width_ok(input int width, input int digit);
        return (digit > 0) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/seq_borrow_subtractor_bla_slice.sv
// Combinational borrow-lookahead slice: d = a - b - i_bin over DIGIT bits.
// Generate g = ~a & b, propagate p = ~(a ^ b); borrow chain br[i+1] = g | p & br.
module bla_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_bin,
    output logic [DIGIT-1:0] o_d,
    output logic             o_bout
);

    logic [DIGIT-1:0] w_g;
    logic [DIGIT-1:0] w_p;
    logic [DIGIT:0]   w_br;

    // Borrow chain across the slice, seeded with the incoming borrow
    always_comb begin
        w_g     = ~i_a & i_b;
        w_p     = ~(i_a ^ i_b);
        w_br    = '0;
        w_br[0] = i_bin;
        for (int i = 0; i < DIGIT; i++) begin
            w_br[i+1] = w_g[i] | (w_p[i] & w_br[i]);
        end
    end

    assign o_d    = i_a ^ i_b ^ w_br[DIGIT-1:0];
    assign o_bout = w_br[DIGIT];

endmodule

// File: rtl/seq_borrow_subtractor.sv
// Word-serial unsigned subtractor: diff = a - b - bin, one DIGIT-bit slice
// per cycle, LSB slice first, slice borrow registered between cycles.
// Build option: define SUB_SAT_EN to saturate a borrowing result at zero
// (bout still reports the borrow). Port list is the same in both builds.
module seq_borrow_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
        $error("seq_borrow_subtractor: WIDTH must be a multiple of DIGIT");
    end

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_borrow;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_out_valid;
    logic               r_busy;

    logic [DIGIT-1:0]   w_a_slice;
    logic [DIGIT-1:0]   w_b_slice;
    logic [DIGIT-1:0]   w_d;
    logic               w_bout;
    logic               w_last;

    // Select the operand slice addressed by the digit counter
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_a_slice = r_a[i*DIGIT +: DIGIT];
                w_b_slice = r_b[i*DIGIT +: DIGIT];
            end else begin
                w_a_slice = w_a_slice;
                w_b_slice = w_b_slice;
            end
        end
    end

    assign w_last = (r_cnt == CNT_W'(NDIG - 1));

    bla_slice #(.DIGIT(DIGIT)) u_slice (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // Control FSM with counter, operand, borrow and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_borrow    <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            r_diff[i*DIGIT +: DIGIT] <= w_d;
                        end
                    end
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bout      <= w_bout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
`ifdef SUB_SAT_EN
                        // A final borrow means a negative result: clamp to zero
                        if (w_bout) begin
                            r_diff <= '0;
                        end
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) & ~rst;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign busy      = r_busy;

endmodule

// File: tb/tb_seq_borrow_subtractor.sv
// Directed self-checking bench for seq_borrow_subtractor (WIDTH=16, DIGIT=4).
// Honours SUB_SAT_EN when defined for the saturating expectations.
module tb_seq_borrow_subtractor;

    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SUB_SAT_EN
    localparam logic [15:0] NEG_DIFF = 16'h0000;
`else
    localparam logic [15:0] NEG_DIFF = 16'hFFFF;
`endif

    seq_borrow_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one operand set at a negedge and let the next edge accept it
    task automatic send_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        a        = av;
        b        = bv;
        bin      = cv;
        in_valid = 1'b1;
        check_value("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_value("busy_run", {31'd0, busy}, 32'd1);
    endtask

    // Wait (bounded) for out_valid, then check latency and result
    task automatic wait_result(input string tag, input logic [15:0] ed, input logic eb);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_latency"}, n, NDIG);
        check_value({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
        check_value({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    endtask

    // Handshake the result away and confirm return to IDLE with diff held
    task automatic release_result(input logic [15:0] ed);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_value("out_valid_drop", {31'd0, out_valid}, 32'd0);
        check_value("busy_drop", {31'd0, busy}, 32'd0);
        check_value("in_ready_back", {31'd0, in_ready}, 32'd1);
        check_value("diff_held_idle", {16'd0, diff}, {16'd0, ed});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        bin       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_value("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_value("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_diff", {16'd0, diff}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: no inter-slice borrow
        send_op(16'h1234, 16'h0234, 1'b0);
        wait_result("t1", 16'h1000, 1'b0);
        release_result(16'h1000);

        // 2: borrow ripples across three slices
        send_op(16'h1000, 16'h0001, 1'b0);
        wait_result("t2", 16'h0FFF, 1'b0);
        release_result(16'h0FFF);

        // 3: underflow
        send_op(16'h0000, 16'h0001, 1'b0);
        wait_result("t3", NEG_DIFF, 1'b1);
        release_result(NEG_DIFF);

        // 4: equal operands with borrow in
        send_op(16'h8000, 16'h8000, 1'b1);
        wait_result("t4", NEG_DIFF, 1'b1);
        release_result(NEG_DIFF);

        // mixed digits with borrow in: ABCD - 1234 - 1
        send_op(16'hABCD, 16'h1234, 1'b1);
        wait_result("t_mix", 16'h9998, 1'b0);
        release_result(16'h9998);

        // 5: backpressure with a pending new operand
        send_op(16'h5555, 16'h1111, 1'b0);
        wait_result("t5", 16'h4444, 1'b0);
        a        = 16'hFFFF;
        b        = 16'h0000;
        bin      = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_value("t5_stall_diff", {16'd0, diff}, 32'h4444);
            check_value("t5_stall_bout", {31'd0, bout}, 32'd0);
            check_value("t5_stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_value("t5_stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_value("t5_resume_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("t5_next", 16'hFFFE, 1'b0);
        release_result(16'hFFFE);

        // 6: reset during the second RUN cycle, then a fresh operation
        send_op(16'h00F0, 16'h0010, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_value("t6_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("t6_busy", {31'd0, busy}, 32'd0);
        check_value("t6_diff", {16'd0, diff}, 32'd0);
        check_value("t6_bout", {31'd0, bout}, 32'd0);
        check_value("t6_in_ready_rst", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_value("t6_in_ready_after", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        send_op(16'h00F0, 16'h0010, 1'b0);
        wait_result("t6_fresh", 16'h00E0, 1'b0);
        release_result(16'h00E0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
